// File: rtl/noc_inj_pkg.sv
// Shared constants for the NoC injection scheduler and the dataout buffer generators.
// State encodings and the node-index width helper live here so both sides agree.
package noc_inj_pkg;

  localparam int DEF_PKT_FLITS  = 30;
  localparam int DEF_GAP_CYCLES = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_INJECT = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;
  localparam logic [1:0] ST_FIN    = 2'd3;

  function automatic int node_w(input int num_nodes);
    return (num_nodes > 1) ? $clog2(num_nodes) : 1;
  endfunction

endpackage

// File: rtl/inj_node_pick.sv
// Combinational find-first-set over the pending-node mask.
// The lowest set bit wins; any flags that at least one node is still pending.
module inj_node_pick #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] pend,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    // Scan downwards so the last hit assigned is the lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inject_scheduler.sv
// Walks a node mask in ascending order, enabling one dataout buffer at a time until it has
// delivered a full packet, with an idle gap between nodes. INJ_TIMEOUT_EN adds a silence watchdog.
//
// state  | meaning
// IDLE   | waiting for start
// INJECT | enable[cur_node] held, counting valid flits
// GAP    | enable low, counting idle cycles before next node or FIN
// FIN    | done pulse, busy drops, back to IDLE
module inject_scheduler
  import noc_inj_pkg::*;
#(
  parameter int NUM_NODES  = 16,
  parameter int PKT_FLITS  = DEF_PKT_FLITS,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             RST,
  input  logic                             start,
  input  logic [NUM_NODES-1:0]             node_mask,
  input  logic [NUM_NODES-1:0]             out_valid,
  output logic [NUM_NODES-1:0]             enable,
  output logic [node_w(NUM_NODES)-1:0]     cur_node,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int NODE_W   = node_w(NUM_NODES);
  localparam int VC_W     = $clog2(PKT_FLITS + 1);
  localparam int GC_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  logic [1:0]           state;
  logic [NUM_NODES-1:0] pend;
  logic [VC_W-1:0]      vcnt;
  logic [GC_W-1:0]      gcnt;
  logic [NUM_NODES-1:0] cur_oh;
  logic [NUM_NODES-1:0] pick_src;
  logic [NODE_W-1:0]    pick_idx;
  logic                 pick_any;
  logic                 valid_cur;
  logic                 timeout;
  logic                 finish;

  assign cur_oh    = NUM_NODES'(1) << cur_node;
  assign valid_cur = out_valid[cur_node];
  assign finish    = (state == ST_INJECT) &&
                     ((valid_cur && (vcnt == VC_W'(PKT_FLITS - 1))) || timeout);

  // In INJECT the picker looks past the node being retired so a zero gap can chain directly.
  always_comb begin
    pick_src = pend;
    if (state == ST_IDLE)
      pick_src = node_mask;
    else if (state == ST_INJECT)
      pick_src = pend & ~cur_oh;
  end

  inj_node_pick #(
    .N (NUM_NODES),
    .W (NODE_W)
  ) u_pick (
    .pend (pick_src),
    .idx  (pick_idx),
    .any  (pick_any)
  );

`ifdef INJ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog;
  logic            err_q;

  assign timeout = (state == ST_INJECT) && !valid_cur && (wdog == WD_W'(TIMEOUT - 1));
  assign err     = err_q;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state != ST_INJECT || finish || valid_cur)
        wdog <= '0;
      else
        wdog <= wdog + 1'b1;
      if (timeout)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      pend     <= '0;
      vcnt     <= '0;
      gcnt     <= '0;
      enable   <= '0;
      cur_node <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pend <= node_mask;
            busy <= 1'b1;
            vcnt <= '0;
            if (pick_any) begin
              state    <= ST_INJECT;
              cur_node <= pick_idx;
              enable   <= NUM_NODES'(1) << pick_idx;
            end else begin
              state <= ST_FIN;
              done  <= 1'b1;
            end
          end
        end
        ST_INJECT: begin
          if (valid_cur && (vcnt != VC_W'(PKT_FLITS)))
            vcnt <= vcnt + 1'b1;
          if (finish) begin
            enable <= '0;
            pend   <= pend & ~cur_oh;
            if (GAP_CYCLES != 0) begin
              state <= ST_GAP;
              gcnt  <= GC_W'(GAP_LAST);
            end else if (pick_any) begin
              cur_node <= pick_idx;
              vcnt     <= '0;
            end else begin
              state <= ST_FIN;
              done  <= 1'b1;
            end
          end else begin
            // Re-entry from GAP leaves enable low for one cycle; it rises here.
            enable <= cur_oh;
          end
        end
        ST_GAP: begin
          if (gcnt == '0) begin
            if (pick_any) begin
              state    <= ST_INJECT;
              cur_node <= pick_idx;
              vcnt     <= '0;
            end else begin
              state <= ST_FIN;
              done  <= 1'b1;
            end
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
